// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared control-bus field indices, size codes and mem stage FSM type
package mips_pkg;

    localparam int CTRL_SRC_HI   = 17;
    localparam int CTRL_SRC_LO   = 15;
    localparam int CTRL_ALUOP_HI = 14;
    localparam int CTRL_ALUOP_LO = 11;
    localparam int CTRL_BRANCH   = 10;
    localparam int CTRL_LOAD     = 9;
    localparam int CTRL_RFEN     = 8;
    localparam int CTRL_TA       = 7;
    localparam int CTRL_STORE    = 6;
    localparam int CTRL_SIZE_HI  = 5;
    localparam int CTRL_SIZE_LO  = 4;
    localparam int CTRL_SIGNED   = 3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_lane_fmt.sv
// rtl/mem_lane_fmt.sv - store lane replication / byte enables, load extract / extend, misalignment
module mem_lane_fmt
    import mips_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        signed_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_be_o,
    output logic [31:0] ld_result_o,
    output logic        misaligned_o
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        lane8        = 8'(ld_data_i >> {off_i, 3'b000});
        lane16       = off_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
        st_wdata_o   = st_data_i;
        st_be_o      = 4'b1111;
        ld_result_o  = ld_data_i;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                st_wdata_o  = {4{st_data_i[7:0]}};
                st_be_o     = 4'b0001 << off_i;
                ld_result_o = signed_i ? {{24{lane8[7]}}, lane8} : {24'b0, lane8};
            end
            SZ_HALF: begin
                st_wdata_o   = {2{st_data_i[15:0]}};
                st_be_o      = 4'b0011 << off_i;
                ld_result_o  = signed_i ? {{16{lane16[15]}}, lane16} : {16'b0, lane16};
                misaligned_o = off_i[0];
            end
            // reserved size code 11 behaves as a word access
            default: begin
                misaligned_o = |off_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with req/ack data memory port and ack timeout
module mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int CTRL_W      = 18,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [CTRL_W-1:0] ex_ctrl,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [4:0]        ex_rd,
    input  logic              flush,
    output logic              stall_out,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic [3:0]        dm_be,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic              wb_valid,
    output logic              wb_rf_enable,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              exc_align,
    output logic              exc_bus
);

    localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              signed_q, signed_d;
    logic              rfen_q, rfen_d;
    logic [4:0]        rd_q, rd_d;
    logic              wbv_q, wbv_d;
    logic              wbrf_q, wbrf_d;
    logic [4:0]        wbrd_q, wbrd_d;
    logic [DATA_W-1:0] wbdata_q, wbdata_d;
    logic              exca_q, exca_d;
    logic              excb_q, excb_d;

    logic [1:0]        ex_size;
    logic              ex_load, ex_store, ex_mem;
    logic              in_wait, to_hit;
    logic [1:0]        fmt_size, fmt_off;
    logic [31:0]       fmt_wdata, fmt_ld;
    logic [3:0]        fmt_be;
    logic              fmt_misaligned;
    logic              unused_ctrl;

    assign ex_size  = ex_ctrl[CTRL_SIZE_HI:CTRL_SIZE_LO];
    assign ex_load  = ex_ctrl[CTRL_LOAD];
    assign ex_store = ex_ctrl[CTRL_STORE];
    assign ex_mem   = ex_load | ex_store;
    assign in_wait  = (state_q == ST_WAIT);
    assign to_hit   = (ACK_TIMEOUT != 0) && (cnt_q == TO_LAST);

    assign unused_ctrl = ^{ex_ctrl[CTRL_SRC_HI:CTRL_SRC_LO], ex_ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO],
                           ex_ctrl[CTRL_BRANCH], ex_ctrl[CTRL_TA], ex_ctrl[2:0]};

    // One formatter serves both directions: EX fields for store lanes in IDLE, latched fields for loads in WAIT
    assign fmt_size = in_wait ? size_q : ex_size;
    assign fmt_off  = in_wait ? off_q : ex_alu_result[1:0];

    mem_lane_fmt u_fmt (
        .size_i       (fmt_size),
        .off_i        (fmt_off),
        .signed_i     (signed_q),
        .st_data_i    (ex_store_data),
        .ld_data_i    (dm_rdata),
        .st_wdata_o   (fmt_wdata),
        .st_be_o      (fmt_be),
        .ld_result_o  (fmt_ld),
        .misaligned_o (fmt_misaligned)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        size_d   = size_q;
        off_d    = off_q;
        signed_d = signed_q;
        rfen_d   = rfen_q;
        rd_d     = rd_q;
        wbv_d    = 1'b0;
        wbrf_d   = wbrf_q;
        wbrd_d   = wbrd_q;
        wbdata_d = wbdata_q;
        exca_d   = 1'b0;
        excb_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (ex_valid && !flush) begin
                    if (!ex_mem) begin
                        wbv_d    = 1'b1;
                        wbdata_d = ex_alu_result;
                        wbrf_d   = ex_ctrl[CTRL_RFEN];
                        wbrd_d   = ex_rd;
                    end else if (fmt_misaligned) begin
                        wbv_d  = 1'b1;
                        wbrf_d = 1'b0;
                        wbrd_d = ex_rd;
                        exca_d = 1'b1;
                    end else begin
                        state_d  = ST_WAIT;
                        we_d     = ex_store & ~ex_load;
                        addr_d   = {ex_alu_result[ADDR_W-1:2], 2'b00};
                        wdata_d  = fmt_wdata;
                        be_d     = fmt_be;
                        size_d   = ex_size;
                        off_d    = ex_alu_result[1:0];
                        signed_d = ex_ctrl[CTRL_SIGNED];
                        rfen_d   = ex_ctrl[CTRL_RFEN];
                        rd_d     = ex_rd;
                    end
                end
            end
            ST_WAIT: begin
                if (dm_ack) begin
                    state_d = ST_IDLE;
                    wbv_d   = 1'b1;
                    wbrd_d  = rd_q;
                    if (we_q) begin
                        wbrf_d = 1'b0;
                    end else begin
                        wbrf_d   = rfen_q;
                        wbdata_d = fmt_ld;
                    end
                end else if (to_hit) begin
                    state_d = ST_IDLE;
                    wbv_d   = 1'b1;
                    wbrf_d  = 1'b0;
                    wbrd_d  = rd_q;
                    excb_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            size_q   <= '0;
            off_q    <= '0;
            signed_q <= 1'b0;
            rfen_q   <= 1'b0;
            rd_q     <= '0;
            wbv_q    <= 1'b0;
            wbrf_q   <= 1'b0;
            wbrd_q   <= '0;
            wbdata_q <= '0;
            exca_q   <= 1'b0;
            excb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            size_q   <= size_d;
            off_q    <= off_d;
            signed_q <= signed_d;
            rfen_q   <= rfen_d;
            rd_q     <= rd_d;
            wbv_q    <= wbv_d;
            wbrf_q   <= wbrf_d;
            wbrd_q   <= wbrd_d;
            wbdata_q <= wbdata_d;
            exca_q   <= exca_d;
            excb_q   <= excb_d;
        end
    end

    assign stall_out    = in_wait;
    assign dm_req       = in_wait;
    assign dm_we        = we_q;
    assign dm_addr      = addr_q;
    assign dm_wdata     = wdata_q;
    assign dm_be        = be_q;
    assign wb_valid     = wbv_q;
    assign wb_rf_enable = wbrf_q;
    assign wb_rd        = wbrd_q;
    assign wb_data      = wbdata_q;
    assign exc_align    = exca_q;
    assign exc_bus      = excb_q;

endmodule
